// File: rtl/exc_commit.sv
// exc_commit: precise-exception commit unit in the MEM stage.
// It picks the highest-priority exception cause of the MEM instruction,
// including a pending interrupt. It waits until the data bus is idle. It then
// issues a one-cycle record to CP0, a pipeline flush and a redirect PC.
//
// Optional feature macro: EXC_BADVADDR_EN
//   defined   : bad-address capture register present, bad_addr_o driven
//   undefined : bad_addr_o tied to 32'h0
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   valid_m, stall_m          MEM slot valid / MEM stage stalled
//   pc_m, in_delayslot_m      MEM instruction PC and delay-slot flag
//   adel_if .. eret_m         per-instruction exception flags
//   mem_addr_m                load/store effective address
//   cp0_status/cause/epc      current CP0 register values
//   data_req_busy             data-side transaction outstanding
//   excepttype_o              exception code to CP0 (nonzero one cycle)
//   current_inst_addr_o       faulting PC to CP0
//   is_in_delayslot_o         delay-slot flag to CP0
//   bad_addr_o                bad virtual address to CP0
//   flush_o, newpc_o          one-cycle flush and redirect target
//   exc_busy_o                pipeline stall request while commit pending
module exc_commit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_m,
   input  logic        stall_m,
   input  logic [31:0] pc_m,
   input  logic        in_delayslot_m,
   input  logic        adel_if,
   input  logic        adel_ld,
   input  logic        ades_st,
   input  logic        ri_m,
   input  logic        ov_m,
   input  logic        syscall_m,
   input  logic        break_m,
   input  logic        eret_m,
   input  logic [31:0] mem_addr_m,
   input  logic [31:0] cp0_status,
   input  logic [31:0] cp0_cause,
   input  logic [31:0] cp0_epc,
   input  logic        data_req_busy,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] newpc_o,
   output logic        exc_busy_o
);

   localparam logic [31:0] CODE_INT  = 32'h0000_0001;
   localparam logic [31:0] CODE_ADEL = 32'h0000_0004;
   localparam logic [31:0] CODE_ADES = 32'h0000_0005;
   localparam logic [31:0] CODE_SYS  = 32'h0000_0008;
   localparam logic [31:0] CODE_BP   = 32'h0000_0009;
   localparam logic [31:0] CODE_RI   = 32'h0000_000a;
   localparam logic [31:0] CODE_OV   = 32'h0000_000c;
   localparam logic [31:0] CODE_ERET = 32'h0000_000e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BUS = 2'd1,
      COMMIT   = 2'd2
   } state_t;

   state_t      state;
   logic        int_req_q;
   logic [31:0] cap_code;
   logic [31:0] cap_pc;
   logic        cap_ds;
   logic [31:0] cap_newpc;

   logic        any_flag_c;
   logic        candidate_c;
   logic        cap_en_c;
   logic        load_sel_c;
   logic        load_cap_c;
   logic [31:0] sel_code_c;
   logic [31:0] sel_newpc_c;

   // Candidate detection and commit-path enables
   assign any_flag_c  = adel_if | adel_ld | ades_st | ri_m | ov_m |
                        syscall_m | break_m | eret_m;
   assign candidate_c = valid_m & ~stall_m & (int_req_q | any_flag_c);
   assign cap_en_c    = (state == IDLE) & candidate_c;
   assign load_sel_c  = cap_en_c & ~data_req_busy;
   assign load_cap_c  = (state == WAIT_BUS) & ~data_req_busy;

   // Cause priority encoder, highest first
   always_comb begin
      sel_code_c = 32'h0;
      if (int_req_q)      sel_code_c = CODE_INT;
      else if (adel_if)   sel_code_c = CODE_ADEL;
      else if (ri_m)      sel_code_c = CODE_RI;
      else if (ov_m)      sel_code_c = CODE_OV;
      else if (syscall_m) sel_code_c = CODE_SYS;
      else if (break_m)   sel_code_c = CODE_BP;
      else if (adel_ld)   sel_code_c = CODE_ADEL;
      else if (ades_st)   sel_code_c = CODE_ADES;
      else if (eret_m)    sel_code_c = CODE_ERET;
   end

   // eret returns to EPC only when it is the winning cause
   assign sel_newpc_c = (sel_code_c == CODE_ERET) ? cp0_epc : EXC_VECTOR;

   // Commit FSM with capture and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         int_req_q           <= 1'b0;
         cap_code            <= 32'h0;
         cap_pc              <= 32'h0;
         cap_ds              <= 1'b0;
         cap_newpc           <= 32'h0;
         excepttype_o        <= 32'h0;
         current_inst_addr_o <= 32'h0;
         is_in_delayslot_o   <= 1'b0;
         flush_o             <= 1'b0;
         newpc_o             <= 32'h0;
         exc_busy_o          <= 1'b0;
      end else begin
         // Interrupt state is seen one cycle late by design
         int_req_q <= (|(cp0_status[15:8] & cp0_cause[15:8])) &
                      cp0_status[0] & ~cp0_status[1];
         case (state)
            IDLE: begin
               if (candidate_c) begin
                  cap_code   <= sel_code_c;
                  cap_pc     <= pc_m;
                  cap_ds     <= in_delayslot_m;
                  cap_newpc  <= sel_newpc_c;
                  exc_busy_o <= 1'b1;
                  if (!data_req_busy) begin
                     state               <= COMMIT;
                     excepttype_o        <= sel_code_c;
                     current_inst_addr_o <= pc_m;
                     is_in_delayslot_o   <= in_delayslot_m;
                     flush_o             <= 1'b1;
                     newpc_o             <= sel_newpc_c;
                  end else begin
                     state <= WAIT_BUS;
                  end
               end
            end
            WAIT_BUS: begin
               if (!data_req_busy) begin
                  state               <= COMMIT;
                  excepttype_o        <= cap_code;
                  current_inst_addr_o <= cap_pc;
                  is_in_delayslot_o   <= cap_ds;
                  flush_o             <= 1'b1;
                  newpc_o             <= cap_newpc;
               end
            end
            COMMIT: begin
               state             <= IDLE;
               excepttype_o      <= 32'h0;
               is_in_delayslot_o <= 1'b0;
               flush_o           <= 1'b0;
               newpc_o           <= 32'h0;
               exc_busy_o        <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef EXC_BADVADDR_EN
   logic [31:0] cap_badaddr;
   logic [31:0] sel_badaddr_c;
   logic        unused_bits_c;

   // Faulting PC for fetch errors, data address for load/store errors
   always_comb begin
      sel_badaddr_c = 32'h0;
      if (int_req_q)                                sel_badaddr_c = 32'h0;
      else if (adel_if)                             sel_badaddr_c = pc_m;
      else if (ri_m | ov_m | syscall_m | break_m)   sel_badaddr_c = 32'h0;
      else if (adel_ld | ades_st)                   sel_badaddr_c = mem_addr_m;
   end

   // Bad-address capture and output, held between commits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_badaddr <= 32'h0;
         bad_addr_o  <= 32'h0;
      end else begin
         if (cap_en_c)        cap_badaddr <= sel_badaddr_c;
         if (load_sel_c)      bad_addr_o  <= sel_badaddr_c;
         else if (load_cap_c) bad_addr_o  <= cap_badaddr;
      end
   end

   assign unused_bits_c = ^{cp0_status[31:16], cp0_status[7:2],
                            cp0_cause[31:16], cp0_cause[7:0]};
`else
   logic unused_bits_c;

   assign bad_addr_o    = 32'h0;
   assign unused_bits_c = ^{cp0_status[31:16], cp0_status[7:2],
                            cp0_cause[31:16], cp0_cause[7:0], mem_addr_m};
`endif

endmodule

// File: tb/tb_exc_commit.sv
// Directed testbench for exc_commit.
module tb_exc_commit;

   logic        clk;
   logic        rst;
   logic        valid_m, stall_m, in_delayslot_m;
   logic [31:0] pc_m, mem_addr_m;
   logic        adel_if, adel_ld, ades_st, ri_m, ov_m, syscall_m, break_m, eret_m;
   logic [31:0] cp0_status, cp0_cause, cp0_epc;
   logic        data_req_busy;
   logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
   logic        is_in_delayslot_o, flush_o, exc_busy_o;

   int unsigned passed;
   int unsigned total;

`ifdef EXC_BADVADDR_EN
   localparam logic BADV = 1'b1;
`else
   localparam logic BADV = 1'b0;
`endif

   exc_commit dut (
      .clk                 (clk),
      .rst                 (rst),
      .valid_m             (valid_m),
      .stall_m             (stall_m),
      .pc_m                (pc_m),
      .in_delayslot_m      (in_delayslot_m),
      .adel_if             (adel_if),
      .adel_ld             (adel_ld),
      .ades_st             (ades_st),
      .ri_m                (ri_m),
      .ov_m                (ov_m),
      .syscall_m           (syscall_m),
      .break_m             (break_m),
      .eret_m              (eret_m),
      .mem_addr_m          (mem_addr_m),
      .cp0_status          (cp0_status),
      .cp0_cause           (cp0_cause),
      .cp0_epc             (cp0_epc),
      .data_req_busy       (data_req_busy),
      .excepttype_o        (excepttype_o),
      .current_inst_addr_o (current_inst_addr_o),
      .is_in_delayslot_o   (is_in_delayslot_o),
      .bad_addr_o          (bad_addr_o),
      .flush_o             (flush_o),
      .newpc_o             (newpc_o),
      .exc_busy_o          (exc_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Outputs when no commit is presented (address outputs checked separately)
   task automatic check_quiet(input string tag);
      check({tag, ".type"},  excepttype_o, 32'h0);
      check({tag, ".flush"}, 32'(flush_o), 32'h0);
      check({tag, ".newpc"}, newpc_o, 32'h0);
      check({tag, ".ds"},    32'(is_in_delayslot_o), 32'h0);
   endtask

   task automatic check_commit(input string tag, input logic [31:0] code,
                               input logic [31:0] pc, input logic ds,
                               input logic [31:0] bad, input logic [31:0] npc);
      check({tag, ".type"},  excepttype_o, code);
      check({tag, ".pc"},    current_inst_addr_o, pc);
      check({tag, ".ds"},    32'(is_in_delayslot_o), 32'(ds));
      check({tag, ".bad"},   bad_addr_o, BADV ? bad : 32'h0);
      check({tag, ".flush"}, 32'(flush_o), 32'h1);
      check({tag, ".newpc"}, newpc_o, npc);
      check({tag, ".busy"},  32'(exc_busy_o), 32'h1);
   endtask

   task automatic clear_inst();
      valid_m = 0; stall_m = 0; in_delayslot_m = 0; pc_m = 0; mem_addr_m = 0;
      adel_if = 0; adel_ld = 0; ades_st = 0; ri_m = 0; ov_m = 0;
      syscall_m = 0; break_m = 0; eret_m = 0;
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst = 1'b1;
      clear_inst();
      cp0_status = 0; cp0_cause = 0; cp0_epc = 0; data_req_busy = 0;
      #1;
      check_quiet("reset");
      check("reset.busy", 32'(exc_busy_o), 32'h0);
      check("reset.pc",   current_inst_addr_o, 32'h0);
      check("reset.bad",  bad_addr_o, 32'h0);
      step();
      step();
      rst = 1'b0;
      step();

      // Syscall, bus idle
      valid_m = 1; pc_m = 32'hBFC00100; syscall_m = 1;
      step();
      clear_inst();
      check_commit("sys", 32'h08, 32'hBFC00100, 1'b0, 32'h0, 32'hBFC00380);
      step();
      check_quiet("sys_after");
      check("sys_after.busy", 32'(exc_busy_o), 32'h0);
      check("sys_after.pc_hold", current_inst_addr_o, 32'hBFC00100);

      // ades_st in delay slot while the bus is busy for three edges
      valid_m = 1; pc_m = 32'hBFC00204; in_delayslot_m = 1; ades_st = 1;
      mem_addr_m = 32'h80000003; data_req_busy = 1;
      step();
      clear_inst();
      for (int i = 0; i < 3; i++) begin
         check("ades_wait.busy",  32'(exc_busy_o), 32'h1);
         check("ades_wait.flush", 32'(flush_o), 32'h0);
         if (i == 2) data_req_busy = 0;
         if (i < 2) step();
      end
      step();
      check_commit("ades", 32'h05, 32'hBFC00204, 1'b1, 32'h80000003, 32'hBFC00380);
      step();
      check_quiet("ades_after");
      check("ades_after.bad_hold", bad_addr_o, BADV ? 32'h80000003 : 32'h0);

      // Interrupt beats overflow on the same instruction
      cp0_status = 32'h0000FF01; cp0_cause = 32'h00008000;
      step();
      valid_m = 1; pc_m = 32'hBFC00300; ov_m = 1;
      step();
      clear_inst();
      cp0_status = 0; cp0_cause = 0;
      check_commit("int", 32'h01, 32'hBFC00300, 1'b0, 32'h0, 32'hBFC00380);
      step();
      check_quiet("int_after");

      // EXL set masks the interrupt: overflow commits
      cp0_status = 32'h0000FF03; cp0_cause = 32'h00008000;
      step();
      valid_m = 1; pc_m = 32'hBFC00304; ov_m = 1;
      step();
      clear_inst();
      cp0_status = 0; cp0_cause = 0;
      check_commit("ov_exl", 32'h0c, 32'hBFC00304, 1'b0, 32'h0, 32'hBFC00380);
      step();
      check_quiet("ov_after");

      // eret redirects to EPC
      cp0_epc = 32'hBFC00444;
      valid_m = 1; pc_m = 32'hBFC00400; eret_m = 1;
      step();
      clear_inst();
      check_commit("eret", 32'h0e, 32'hBFC00400, 1'b0, 32'h0, 32'hBFC00444);
      step();
      check_quiet("eret_after");

      // adel_if outranks ri; bad address is the PC
      valid_m = 1; pc_m = 32'hBFC00601; adel_if = 1; ri_m = 1;
      step();
      clear_inst();
      check_commit("adel_if", 32'h04, 32'hBFC00601, 1'b0, 32'hBFC00601, 32'hBFC00380);
      step();

      // Stalled instruction with ri does not capture
      valid_m = 1; stall_m = 1; ri_m = 1; pc_m = 32'hBFC00700;
      step();
      step();
      check_quiet("stall");
      check("stall.busy", 32'(exc_busy_o), 32'h0);
      clear_inst();

      // Back-to-back candidates: only the first commits
      valid_m = 1; pc_m = 32'hBFC00500; break_m = 1;
      step();
      check_commit("b2b_first", 32'h09, 32'hBFC00500, 1'b0, 32'h0, 32'hBFC00380);
      break_m = 0; ri_m = 1; pc_m = 32'hBFC00504;
      step();
      clear_inst();
      check_quiet("b2b_second");
      check("b2b_second.pc_hold", current_inst_addr_o, 32'hBFC00500);
      step();
      check_quiet("b2b_later");
      check("b2b_later.busy", 32'(exc_busy_o), 32'h0);

      // Reset while waiting on the bus
      valid_m = 1; pc_m = 32'hBFC00800; adel_ld = 1; mem_addr_m = 32'h12345679;
      data_req_busy = 1;
      step();
      clear_inst();
      check("rstwait.busy_pre", 32'(exc_busy_o), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_quiet("rstwait");
      check("rstwait.busy", 32'(exc_busy_o), 32'h0);
      check("rstwait.pc",   current_inst_addr_o, 32'h0);
      check("rstwait.bad",  bad_addr_o, 32'h0);
      data_req_busy = 0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_quiet("post_rst");
         check("post_rst.busy", 32'(exc_busy_o), 32'h0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/exc_commit.md
# exc_commit

Precise-exception commit unit in the MEM stage of the sram-like MIPS core. It samples per-instruction exception flags and the CP0 interrupt state, then selects the highest-priority cause. It waits for any outstanding data-bus transaction to finish, then issues a one-cycle exception record to CP0 together with a pipeline flush and the redirect PC. For `eret`, the redirect target is EPC and excepttype 0x0e is sent so CP0 clears EXL.

## Interface
- `EXC_VECTOR`, 32'hBFC00380, redirect target for all exceptions except `eret`.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_m`  in  1  MEM-stage slot holds a real instruction.
- `stall_m`  in  1  MEM stage stalled; no detection this cycle.
- `pc_m`  in  32  PC of the MEM-stage instruction.
- `in_delayslot_m`  in  1  MEM instruction is in a branch delay slot.
- `adel_if`, `adel_ld`, `ades_st`, `ri_m`, `ov_m`, `syscall_m`, `break_m`, `eret_m`  in  1 each  exception flags carried with the instruction.
- `mem_addr_m`  in  32  load/store effective address.
- `cp0_status`, `cp0_cause`, `cp0_epc`  in  32 each  current CP0 register values.
- `data_req_busy`  in  1  data-side sram-like transaction outstanding.
- `excepttype_o`  out  32  exception code to CP0; nonzero for exactly one cycle per commit.
- `current_inst_addr_o`  out  32  faulting PC to CP0.
- `is_in_delayslot_o`  out  1  delay-slot flag to CP0.
- `bad_addr_o`  out  32  bad virtual address to CP0.
- `flush_o`  out  1  one-cycle flush of IF..MEM.
- `newpc_o`  out  32  redirect PC; valid while `flush_o`=1.
- `exc_busy_o`  out  1  stall request to the pipeline while a commit is pending.

## Operation
- Interrupt request is registered each cycle: `int_req_q <= |(status[15:8] & cause[15:8]) & status[0] & ~status[1]`.
- A candidate exists when `valid_m & ~stall_m` and either `int_req_q` is set or any flag is set.
- Priority and codes, highest first:
  - interrupt 0x01
  - adel_if 0x04
  - ri 0x0a
  - ov 0x0c
  - syscall 0x08
  - break 0x09
  - adel_ld 0x04
  - ades_st 0x05
  - eret 0x0e
- Code 0x0d is never generated.
- Capture registers hold code, `pc_m`, `in_delayslot_m`, bad address, and the redirect target. Bad address is `pc_m` for adel_if and `mem_addr_m` for adel_ld/ades_st; 0 otherwise. Redirect target is `cp0_epc` for eret; `EXC_VECTOR` otherwise.
- FSM states: IDLE, WAIT_BUS, COMMIT.
  - IDLE: on a candidate, capture. Go to COMMIT if `data_req_busy`=0, else go to WAIT_BUS.
  - WAIT_BUS: hold captured values. Go to COMMIT on the first cycle `data_req_busy`=0.
  - COMMIT: drive `excepttype_o`, `current_inst_addr_o`, `is_in_delayslot_o`, `bad_addr_o`, `flush_o`=1, and `newpc_o` from the capture registers. Return to IDLE next cycle.
- `exc_busy_o`=1 in WAIT_BUS and COMMIT.
- New candidates are ignored outside IDLE.
- Outside COMMIT, `excepttype_o`, `flush_o`, and `newpc_o` are 0.
- `current_inst_addr_o` and `bad_addr_o` hold their last values; `is_in_delayslot_o` is 0.

## Timing
- Reset values: state IDLE, `int_req_q`=0, all capture registers 0, every output 0.
- Latency: candidate at edge N with bus idle gives the COMMIT outputs in cycle N+1, exactly one cycle wide.
- If busy: COMMIT occurs in the cycle after the first edge that sees `data_req_busy`=0.
- Interrupt is sampled one cycle late. An interrupt enabled by MTC0 at cycle N is visible to the instruction in MEM at cycle N+1 or later.
- Interrupt and a synchronous flag on the same instruction: interrupt wins, code 0x01.
- `stall_m`=1 blocks capture even when flags are set.
- Reset asserted in any state: asynchronously returns to IDLE and forces all outputs to 0 immediately.
- CP0 samples on negedge, so the COMMIT values are stable from posedge through negedge.

## Configuration
- `EXC_BADVADDR_EN` defined: bad-address capture register present, and `bad_addr_o` driven as specified.
- Not defined: capture register removed and `bad_addr_o` tied to 32'h0. All other behaviour is unchanged.

## Test plan
- Syscall, PC 0xBFC00100, not in delay slot, bus idle -> next cycle: excepttype 0x08, addr 0xBFC00100, delayslot 0, flush 1, newpc 0xBFC00380; one cycle only.
- ades_st at PC 0xBFC00204 in delay slot, `mem_addr_m`=0x80000003, `data_req_busy` high for 3 cycles -> `exc_busy_o` high through the wait; one COMMIT cycle after busy drops with code 0x05, delayslot 1, bad_addr 0x80000003 (0 with `EXC_BADVADDR_EN` undefined).
- status=0x0000FF01, cause[15:8]=0x80, instruction also has ov_m -> code 0x01 committed, not 0x0c. Same with status[1]=1 -> code 0x0c.
- eret with `cp0_epc`=0xBFC00444 -> code 0x0e, newpc 0xBFC00444.
- `stall_m`=1 with ri_m set -> no capture. Two back-to-back candidates -> only the first commits.
- Assert `rst` while in WAIT_BUS -> outputs 0 immediately. After release, no stale COMMIT occurs.
